// File: rtl/stopwatch_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module : stopwatch_disp_pkg
// Brief  : Shared encodings for the stopwatch 7-segment scan display.
// Rev    : 1.0  initial release
// ============================================================================
package stopwatch_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_BAD   = 2'b11
    } disp_state_t;

    localparam int NUM_DIGITS = 4;

    // Active-low segment patterns, bit0 = a .. bit6 = g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit-buffer code that renders as an unlit digit
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_display_scan_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module : bin2bcd_seq
// Brief  : Start/done sequential double-dabble, 8-bit binary -> 3 BCD digits in 8 cycles.
// Rev    : 1.0  initial release
// ============================================================================
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_bin,
    output logic        o_done,
    output logic [11:0] o_bcd
);
    logic [19:0] r_sr;
    logic [2:0]  r_cnt;
    logic        r_busy;
    logic        r_done;

    // Add-3 to every BCD nibble >= 5, then shift the whole register left by one
    function automatic logic [19:0] dabble_step(input logic [19:0] sr);
        logic [19:0] t;
        t = sr;
        for (int n = 0; n < 3; n++) begin
            if (t[8 + 4*n +: 4] >= 4'd5) begin
                t[8 + 4*n +: 4] = t[8 + 4*n +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_sr   <= {12'd0, i_bin};
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_sr  <= dabble_step(r_sr);
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_bcd  = r_sr[19:8];

endmodule
`default_nettype wire

// File: rtl/stopwatch_display_scan.sv
`default_nettype none
// ============================================================================
// Module : stopwatch_display_scan
// Brief  : Multiplexed 4-digit MM:SS 7-segment driver fed from a per-frame snapshot.
//          Optional build macro LEADING_ZERO_BLANK_EN blanks a minute-tens zero.
// Rev    : 1.0  initial release
// ============================================================================
module stopwatch_display_scan
    import stopwatch_disp_pkg::*;
#(
    parameter int DIGIT_CYCLES = 1000,
    parameter int GUARD_CYCLES = 2,
    parameter int BLINK_CYCLES = 1 << 24
) (
    input  logic       i_sys_clk,
    input  logic       i_hw_reset_n,
    input  logic [7:0] i_val_min,
    input  logic [5:0] i_val_sec,
    input  logic [1:0] i_fsm_state,
    output logic [6:0] o_seg_n,
    output logic       o_dp_n,
    output logic [3:0] o_an_n,
    output logic       o_ovf
);
    localparam int SLOT_W  = $clog2(DIGIT_CYCLES);
    localparam int BLINK_W = $clog2(BLINK_CYCLES);
    localparam logic [SLOT_W-1:0]  c_slot_last  = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  c_guard      = SLOT_W'(GUARD_CYCLES);
    localparam logic [BLINK_W-1:0] c_blink_last = BLINK_W'(BLINK_CYCLES - 1);

    logic [SLOT_W-1:0]  r_slot;
    logic [1:0]         r_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_on;
    logic               r_started;
    disp_state_t        r_snap_state;
    disp_state_t        r_state;
    logic [3:0]         r_dig [NUM_DIGITS];
    logic               r_ovf;
    logic [6:0]         r_seg_n;
    logic               r_dp_n;
    logic [3:0]         r_an_n;
    logic               r_ovf_q;

    logic        w_snap;
    logic        w_min_done;
    logic        w_sec_done;
    logic        w_done;
    logic [11:0] w_min_bcd;
    logic [11:0] w_sec_bcd;
    logic        w_min_ovf;
    logic        w_unused_sec_hund;

    assign w_snap            = !r_started || ((r_slot == c_slot_last) && (r_idx == 2'd3));
    assign w_done            = w_min_done && w_sec_done;
    assign w_min_ovf         = (w_min_bcd[11:8] != 4'd0);
    assign w_unused_sec_hund = ^w_sec_bcd[11:8];

    bin2bcd_seq u_min_bcd (
        .clk     (i_sys_clk),
        .rst_n   (i_hw_reset_n),
        .i_start (w_snap),
        .i_bin   (i_val_min),
        .o_done  (w_min_done),
        .o_bcd   (w_min_bcd)
    );

    bin2bcd_seq u_sec_bcd (
        .clk     (i_sys_clk),
        .rst_n   (i_hw_reset_n),
        .i_start (w_snap),
        .i_bin   ({2'b00, i_val_sec}),
        .o_done  (w_sec_done),
        .o_bcd   (w_sec_bcd)
    );

    // Scan, blink and snapshot bookkeeping
    always_ff @(posedge i_sys_clk or negedge i_hw_reset_n) begin
        if (!i_hw_reset_n) begin
            r_slot       <= '0;
            r_idx        <= '0;
            r_blink_cnt  <= '0;
            r_blink_on   <= 1'b1;
            r_started    <= 1'b0;
            r_snap_state <= ST_IDLE;
            r_state      <= ST_IDLE;
            r_ovf        <= 1'b0;
            for (int n = 0; n < NUM_DIGITS; n++) begin
                r_dig[n] <= DIGIT_BLANK;
            end
        end else begin
            r_started <= 1'b1;
            if (r_slot == c_slot_last) begin
                r_slot <= '0;
                r_idx  <= r_idx + 2'd1;
            end else begin
                r_slot <= r_slot + 1'b1;
            end
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
            if (w_snap) begin
                r_snap_state <= disp_state_t'(i_fsm_state);
            end
            // Whole frame is committed in one edge so no digit ever mixes two snapshots
            if (w_done) begin
                r_state  <= r_snap_state;
                r_ovf    <= w_min_ovf;
                r_dig[3] <= w_min_ovf ? 4'd9 : w_min_bcd[7:4];
                r_dig[2] <= w_min_ovf ? 4'd9 : w_min_bcd[3:0];
                r_dig[1] <= w_sec_bcd[7:4];
                r_dig[0] <= w_sec_bcd[3:0];
            end
        end
    end

    logic       w_lead_blank;
    logic       w_shown;
    logic       w_colon;
    logic [6:0] w_seg_n;
    logic [3:0] w_an_n;
    logic       w_dp_n;

    always_comb begin
        w_lead_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        w_lead_blank = (r_idx == 2'd3) && (r_dig[3] == 4'd0) && (r_state != ST_BAD);
`endif
        w_shown = (r_slot >= c_guard)
               && !((r_state == ST_PAUSE) && !r_blink_on)
               && !w_lead_blank;
        case (r_state)
            ST_IDLE:  w_colon = 1'b1;
            ST_RUN:   w_colon = r_blink_on;
            ST_PAUSE: w_colon = r_blink_on;
            default:  w_colon = 1'b0;
        endcase
        if (r_state == ST_BAD) begin
            w_seg_n = SEG_DASH;
        end else if (w_lead_blank) begin
            w_seg_n = SEG_BLANK;
        end else begin
            w_seg_n = seg_decode(r_dig[r_idx]);
        end
        w_an_n = w_shown ? ~(4'b0001 << r_idx) : 4'hF;
        w_dp_n = !(w_shown && (r_idx == 2'd2) && w_colon);
    end

    always_ff @(posedge i_sys_clk or negedge i_hw_reset_n) begin
        if (!i_hw_reset_n) begin
            r_seg_n <= SEG_BLANK;
            r_dp_n  <= 1'b1;
            r_an_n  <= 4'hF;
            r_ovf_q <= 1'b0;
        end else begin
            r_seg_n <= w_seg_n;
            r_dp_n  <= w_dp_n;
            r_an_n  <= w_an_n;
            r_ovf_q <= r_ovf;
        end
    end

    assign o_seg_n = r_seg_n;
    assign o_dp_n  = r_dp_n;
    assign o_an_n  = r_an_n;
    assign o_ovf   = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display_scan.sv
`default_nettype none
// ============================================================================
// Module : tb_stopwatch_display_scan
// Brief  : Directed + random stimulus against a frame-level display model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_stopwatch_display_scan;
    localparam int D     = 16;
    localparam int G     = 2;
    localparam int B     = 64;
    localparam int FRAME = 4 * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] val_min = '0;
    logic [5:0] val_sec = '0;
    logic [1:0] fsm_state = '0;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic       ovf;

    int tests  = 0;
    int failed = 0;
    int k      = 0;

    // Model of what the display is currently committed to show
    int f_dig [4];
    int f_state;
    int f_ovf;

    typedef struct {
        int eff;
        int mn;
        int sc;
        int st;
    } snap_t;
    snap_t pend [$];

    always #5 clk = ~clk;

    stopwatch_display_scan #(
        .DIGIT_CYCLES (D),
        .GUARD_CYCLES (G),
        .BLINK_CYCLES (B)
    ) dut (
        .i_sys_clk    (clk),
        .i_hw_reset_n (rst_n),
        .i_val_min    (val_min),
        .i_val_sec    (val_sec),
        .i_fsm_state  (fsm_state),
        .o_seg_n      (seg_n),
        .o_dp_n       (dp_n),
        .o_an_n       (an_n),
        .o_ovf        (ovf)
    );

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0;
        for (int n = 0; n < 4; n++) f_dig[n] = 15;
        f_state = 0;
        f_ovf   = 0;
        pend.delete();
    endtask

    task automatic apply(input snap_t s);
        f_state = s.st;
        f_ovf   = (s.mn > 99) ? 1 : 0;
        f_dig[3] = (s.mn > 99) ? 9 : s.mn / 10;
        f_dig[2] = (s.mn > 99) ? 9 : s.mn % 10;
        f_dig[1] = s.sc / 10;
        f_dig[0] = s.sc % 10;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_seg"}, 32'(seg_n), 32'h7F);
        check({tag, "_dp"},  32'(dp_n),  32'h1);
        check({tag, "_an"},  32'(an_n),  32'hF);
        check({tag, "_ovf"}, 32'(ovf),   32'h0);
    endtask

    // One clock: record snapshots, commit due frames, then check all outputs
    task automatic step();
        snap_t      s;
        int         j, slot, idx;
        bit         on, lead, shown, colon;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        @(posedge clk);
        k++;
        if (k == 1 || (k % FRAME) == 0) begin
            s.eff = k + 10;
            s.mn  = int'(val_min);
            s.sc  = int'(val_sec);
            s.st  = int'(fsm_state);
            pend.push_back(s);
        end
        if (pend.size() > 0 && pend[0].eff == k) apply(pend.pop_front());
        #1;
        j    = k - 1;
        slot = j % D;
        idx  = (j / D) % 4;
        on   = ((j / B) % 2) == 0;
        lead = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lead = (idx == 3) && (f_dig[3] == 0) && (f_state != 3);
`endif
        shown   = (slot >= G) && !(f_state == 2 && !on) && !lead;
        colon   = (f_state == 0) ? 1'b1 : (f_state == 3) ? 1'b0 : on;
        exp_an  = shown ? ~(4'b0001 << idx) : 4'hF;
        exp_dp  = !(shown && idx == 2 && colon);
        exp_seg = (f_state == 3) ? 7'h3F : lead ? 7'h7F : seg_of(f_dig[idx]);
        check("an_n",  32'(an_n),  32'(exp_an));
        check("seg_n", 32'(seg_n), 32'(exp_seg));
        check("dp_n",  32'(dp_n),  32'(exp_dp));
        check("ovf",   32'(ovf),   32'(f_ovf));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("hold_reset");

        // Basic MM:SS rendering in IDLE
        @(negedge clk);
        val_min = 8'd12; val_sec = 6'd34; fsm_state = 2'b00;
        rst_n = 1'b1;
        run(2 * FRAME);

        // Minute overflow, then recovery
        val_min = 8'd150;
        run(2 * FRAME);
        val_min = 8'd7;
        run(2 * FRAME);

        // Seconds change during the digit-2 slot
        val_min = 8'd12; val_sec = 6'd34;
        run(FRAME);
        while ((k % FRAME) != 40) step();
        val_sec = 6'd35;
        run(2 * FRAME);

        // Display states, literal 60..63 seconds and a single-digit minute
        fsm_state = 2'b01; val_sec = 6'd61;
        run(3 * FRAME);
        fsm_state = 2'b10;
        run(3 * FRAME);
        fsm_state = 2'b11;
        run(2 * FRAME);
        fsm_state = 2'b00; val_min = 8'd5; val_sec = 6'd9;
        run(2 * FRAME);

        // Randomized inputs changing at arbitrary points in the frame
        for (int r = 0; r < 120; r++) begin
            val_min   = 8'($urandom_range(0, 255));
            val_sec   = 6'($urandom_range(0, 63));
            fsm_state = 2'($urandom_range(0, 3));
            run(int'($urandom_range(3, 45)));
        end

        // Asynchronous reset in the middle of a frame
        fsm_state = 2'b00; val_min = 8'd42; val_sec = 6'd17;
        run(FRAME);
        while ((k % FRAME) != 20) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
